// File: rtl/ahbl_apb_bridge_multi_pkg.sv
// Shared types and constants for the AHB-Lite to APB3 multi-slot bridge.
package ahbl_apb_pkg;
    localparam int SLOT_W = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_e;
endpackage

// File: rtl/ahbl_apb_bridge_multi_slot_decode.sv
// Slot index to one-hot PSEL decoder with an out-of-range flag.
module apb_slot_decode
    import ahbl_apb_pkg::*;
#(
    parameter int NUM_SLOTS = 16
) (
    input  logic [SLOT_W-1:0]    idx,
    output logic [NUM_SLOTS-1:0] sel,
    output logic                 unmapped
);
    always_comb begin
        sel      = '0;
        unmapped = (32'(idx) >= NUM_SLOTS);
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (32'(idx) == i) sel[i] = 1'b1;
        end
    end
endmodule

// File: rtl/ahbl_apb_bridge_multi.sv
// AHB-Lite slave to APB3 master bridge: slot decode, PREADY wait states,
// PSLVERR/decode/size errors as a two-cycle ERROR, and an ACCESS timeout.
module ahbl_apb_bridge_multi
    import ahbl_apb_pkg::*;
#(
    parameter int NUM_SLOTS  = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SLOT_SHIFT = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADYIN,
    output logic                  HREADYOUT,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HRESP,
    output logic [NUM_SLOTS-1:0]  PSEL,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_e                 state, state_nx;
    logic                   open, accept, size_err, dec_unmapped, tmo;
    logic [NUM_SLOTS-1:0]   dec_sel, psel_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic                   write_q;
    logic [DATA_WIDTH-1:0]  pwdata_q, hrdata_q;
    logic [CNT_W-1:0]       cnt;
    logic                   unused_htrans;

    // HTRANS[0] only separates BUSY/SEQ from IDLE/NONSEQ, which the bridge treats alike.
    assign unused_htrans = HTRANS[0];

    // New transfers are only taken while the bridge is driving HREADYOUT high.
    assign open     = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR2);
    assign accept   = open & HSEL & HREADYIN & HTRANS[1];
    assign size_err = (HSIZE > 3'd2);
    assign tmo      = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    apb_slot_decode #(.NUM_SLOTS(NUM_SLOTS)) u_dec (
        .idx      (HADDR[SLOT_SHIFT +: SLOT_W]),
        .sel      (dec_sel),
        .unmapped (dec_unmapped)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                if (accept) state_nx = (dec_unmapped | size_err) ? ST_ERR1 : ST_SETUP;
                else        state_nx = ST_IDLE;
            end
            ST_SETUP:  state_nx = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY)   state_nx = PSLVERR ? ST_ERR1 : ST_DONE;
                else if (tmo) state_nx = ST_ERR1;
            end
            ST_ERR1:   state_nx = ST_ERR2;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            psel_q   <= '0;
            pwdata_q <= '0;
            hrdata_q <= '0;
            cnt      <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q  <= HADDR;
                write_q <= HWRITE;
                psel_q  <= dec_sel;
            end
            if (state == ST_SETUP) pwdata_q <= HWDATA;
            if (state_nx == ST_SETUP)       cnt <= '0;
            else if (state == ST_ACCESS)    cnt <= cnt + 1'b1;
            if (state == ST_ACCESS && PREADY && !PSLVERR && !write_q) hrdata_q <= PRDATA;
        end
    end

    // PSEL/PENABLE decode straight from state so any ACCESS exit or reset drops them on that edge.
    assign PSEL      = (state == ST_SETUP || state == ST_ACCESS) ? psel_q : '0;
    assign PENABLE   = (state == ST_ACCESS);
    assign PADDR     = addr_q;
    assign PWRITE    = write_q;
    assign PWDATA    = (state == ST_SETUP) ? HWDATA : pwdata_q;
    assign HRDATA    = hrdata_q;
    assign HRESP     = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign HREADYOUT = !(state == ST_SETUP || state == ST_ACCESS || state == ST_ERR1);
endmodule
